// File: rtl/enc_pkg.sv
// Shared types, widths and helpers for the registered 8-to-3 priority encoder.
package enc_pkg;

  localparam int unsigned ENC_IN_W   = 8;
  localparam int unsigned ENC_CODE_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StLocked
  } enc_state_e;

  function automatic logic [3:0] popcount8(input logic [ENC_IN_W-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < ENC_IN_W; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/enc4to2.sv
// 4-to-2 priority encoder for one nibble; bit 3 has the highest priority.
module enc4to2 (
  input  logic [3:0] in_i,
  output logic [1:0] out_o,
  output logic       any_o
);

  always_comb begin
    out_o = 2'd0;
    if (in_i[3]) begin
      out_o = 2'd3;
    end else if (in_i[2]) begin
      out_o = 2'd2;
    end else if (in_i[1]) begin
      out_o = 2'd1;
    end
  end

  assign any_o = |in_i;

endmodule

// File: rtl/prio_enc8.sv
// Registered 8-to-3 priority encoder with per-bit synchronizer and whole-vector debounce.
module prio_enc8
  import enc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [ENC_IN_W-1:0]   d_i,
  output logic [ENC_CODE_W-1:0] code_o,
  output logic                  valid_o,
  output logic                  multi_o,
  output logic                  chg_o
);

  localparam int unsigned CntW = $clog2(DEB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic [ENC_IN_W-1:0]   s1_q, s2_q;
  enc_state_e            state_q, state_d;
  logic [ENC_IN_W-1:0]   cand_q, cand_d;
  logic [ENC_IN_W-1:0]   held_q, held_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ENC_CODE_W-1:0] code_q, code_d;
  logic                  valid_q, valid_d;
  logic                  multi_q, multi_d;
  logic                  chg_q, chg_d;

  logic [1:0]            hi_code, lo_code;
  logic                  hi_any, lo_any;
  logic [ENC_CODE_W-1:0] cand_code;

  enc4to2 u_enc_hi (
    .in_i  (cand_q[7:4]),
    .out_o (hi_code),
    .any_o (hi_any)
  );

  enc4to2 u_enc_lo (
    .in_i  (cand_q[3:0]),
    .out_o (lo_code),
    .any_o (lo_any)
  );

  // lo_any is implied by |cand_q; the lower nibble only matters when the upper one is empty.
  assign cand_code = {hi_any, hi_any ? hi_code : (lo_any ? lo_code : 2'd0)};

  // Synchronizer runs regardless of en_i so a re-enable sees current pin state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
    multi_d = multi_q;
    chg_d   = 1'b0;

    if (!en_i) begin
      state_d = StIdle;
      cand_d  = '0;
      held_d  = '0;
      cnt_d   = '0;
      code_d  = '0;
      valid_d = 1'b0;
      multi_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s2_q != '0) begin
            state_d = StSettle;
            cand_d  = s2_q;
            cnt_d   = '0;
          end
        end
        StSettle: begin
          if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
          end else if (cnt_q == CntMax) begin
            held_d  = cand_q;
            code_d  = cand_code;
            valid_d = |cand_q;
            multi_d = popcount8(cand_q) > 4'd1;
            chg_d   = cand_q != held_q;
            state_d = (cand_q != '0) ? StLocked : StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StLocked: begin
          // Outputs hold their previous values while the new vector settles.
          if (s2_q != held_q) begin
            state_d = StSettle;
            cand_d  = s2_q;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cand_q  <= '0;
      held_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      chg_q   <= chg_d;
    end
  end

  assign code_o  = code_q;
  assign valid_o = valid_q;
  assign multi_o = multi_q;
  assign chg_o   = chg_q;

endmodule

// File: doc/prio_enc8.md
# prio_enc8

Registered 8-to-3 priority encoder for raw switch and button inputs; it is the encode-side counterpart of the board's 3-to-8 decoder path. Each input bit is synchronized, and the whole vector is debounced as a unit. The highest set bit is encoded into a 3-bit code with a valid flag, a multi-hit flag and a one-cycle change pulse. It sits between the board input pins and the display/decoder logic.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable cycles required before a new input vector is accepted. Legal range is 2..255.
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: synchronous enable. Low forces the block idle and clears its outputs.
- `d` input, 8 bits: raw, asynchronous request lines; bit 7 has highest priority.
- `code` output, 3 bits: index of the highest set bit in the accepted vector.
- `valid` output, 1 bit: accepted vector is nonzero.
- `multi` output, 1 bit: accepted vector has two or more bits set.
- `chg` output, 1 bit: one-cycle pulse when the accepted vector changes value.

## Operation
- **Synchronizer:** two flops per bit, `d` → `s1` → `s2`. Both reset to 0.
- **FSM state IDLE:**
  - If `en` is high and `s2 != 0`: go to SETTLE, load `cand <= s2`, `cnt <= 0`.
- **FSM state SETTLE:**
  - If `s2 != cand`: load `cand <= s2`, `cnt <= 0`, stay in SETTLE.
  - Else if `cnt == DEB_CYCLES-1`: lock `cand`.
  - Else: `cnt <= cnt+1`.
- **FSM state LOCKED:**
  - If `s2 != held`: go to SETTLE, load `cand <= s2`, `cnt <= 0`.
  - Outputs keep their old values during re-settle.
- **Lock action:**
  - Load `held <= cand`, `code <= penc(cand)`, `valid <= |cand`, `multi <= (popcount(cand) > 1)`.
  - Assert `chg` for one cycle iff `cand != held` (the old value of `held`).
  - Next state is LOCKED if `cand != 0`, otherwise IDLE.
- **Zero vector:** locking `cand = 0` after a prior nonzero lock gives `valid = 0`, `code = 0`, `multi = 0` and `chg = 1`. A bounce in IDLE that collapses back to 0 locks 0 against `held = 0`, so `chg` stays 0.
- **Priority encoding:**
  - `code[2] = |cand[7:4]`.
  - `code[1:0]` is the encoding of the upper nibble if that nibble is nonzero, otherwise the encoding of the lower nibble.
- **Counter:** `cnt` is `$clog2(DEB_CYCLES)` bits wide and never wraps, because it is cleared before reaching `DEB_CYCLES`.
- **`en` low:**
  - On the next edge: state IDLE, `held = 0`, all outputs 0, `chg = 0`.
  - The synchronizer keeps running.
- **`en` low on the same edge as a lock:** `en` wins and no lock happens.

## Timing
- **Reset values:** all outputs, plus `s1`, `s2`, `cand`, `cnt` and `held`, are 0; state is IDLE. These apply immediately on `rst_n` low.
- **Reset exit:** state is first evaluated on the first rising edge after `rst_n` deasserts.
- **Reset mid-SETTLE:** the candidate is discarded and no `chg` is produced.
- **Latency:** outputs update DEB_CYCLES+3 rising edges after `d` becomes stable, measured from the first edge that samples the new value. With the default, this is 7.
- **`chg` alignment:** `chg` is high in exactly the cycle that `code`/`valid`/`multi` take their new values.
- **Bounces:** a bounce shorter than DEB_CYCLES+1 cycles at `s2` never changes the outputs.
- **Bus style:** no handshake; outputs are level-valid, and `chg` is the event strobe.

## Structure
- **Shared package:** `enc_pkg` holds the FSM state enum (IDLE, SETTLE, LOCKED), the constants `ENC_IN_W = 8` and `ENC_CODE_W = 3`, and a `popcount8` function.
- **Sub-module `enc4to2`:**
  - Ports: input `in[3:0]`; outputs `out[1:0]` (highest-bit index) and `any`.
  - Instantiated twice, once per nibble, mirroring the two 2-to-4 decoders on the decode side.
- **Top level:** synchronizer, FSM, counter and output registers live in `prio_enc8`.

## Test plan
- Reset, then `d = 8'h00` held for 20 cycles → `valid = 0`, `code = 0`, `chg` never asserted.
- `d = 8'h28`, stable (`DEB_CYCLES = 4`) → on edge 7: `code = 5`, `valid = 1`, `multi = 1`, one-cycle `chg`.
- `d = 8'h01`, then a 3-cycle glitch to `8'h81`, then back to `8'h01` → `code` stays 0 and no second `chg`.
- Locked on `8'h10`, then `d → 8'h00` → 7 edges later: `valid = 0`, `code = 0`, `chg = 1` for one cycle.
- Locked on `8'h04`, drop `en` for one cycle → next edge all outputs 0. Re-raise `en` with `d` unchanged → `code = 2` and `chg` after DEB_CYCLES+1 edges.
- Assert `rst_n` low mid-SETTLE on `8'h80` → outputs 0 immediately. Release → lock after DEB_CYCLES+3 edges with `code = 7`.
